// File: rtl/x86_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : x86_dec_pkg
// Description : Opcodes, parser state encoding and field size codes shared by
//               the x86 byte decoder and its opcode classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package x86_dec_pkg;

    localparam logic [7:0] OP_ADD_RM_R    = 8'h01;
    localparam logic [7:0] OP_ADD_R_RM    = 8'h03;
    localparam logic [7:0] OP_OR_RM_R     = 8'h09;
    localparam logic [7:0] OP_MOV_RM_R    = 8'h89;
    localparam logic [7:0] OP_MOV_R_RM    = 8'h8B;
    localparam logic [7:0] OP_GRP1_IMM32  = 8'h81;
    localparam logic [7:0] OP_GRP1_IMM8   = 8'h83;
    localparam logic [7:0] OP_GRP2_IMM8   = 8'hC1;
    localparam logic [7:0] OP_ADD_EAX_IMM = 8'h05;
    localparam logic [7:0] OP_OR_EAX_IMM  = 8'h0D;
    localparam logic [7:0] OP_JMP_REL8    = 8'hEB;
    localparam logic [7:0] OP_CALL_REL32  = 8'hE8;
    localparam logic [7:0] OP_JMP_REL32   = 8'hE9;
    localparam logic [7:0] OP_RET         = 8'hC3;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_8    = 2'b01;
    localparam logic [1:0] SZ_32   = 2'b10;

    typedef enum logic [2:0] {
        ST_OPC   = 3'd0,
        ST_MODRM = 3'd1,
        ST_DISP  = 3'd2,
        ST_IMM   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Fields are consumed in stream order: modrm, displacement, immediate.
    function automatic state_t next_field(input logic   illegal,
                                          input logic   need_modrm,
                                          input logic [1:0] disp_size,
                                          input logic [1:0] imm_size);
        if (illegal)                    return ST_DONE;
        else if (need_modrm)            return ST_MODRM;
        else if (disp_size != SZ_NONE)  return ST_DISP;
        else if (imm_size != SZ_NONE)   return ST_IMM;
        else                            return ST_DONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/x86_opcode_class.sv
`default_nettype none
// ============================================================================
// Module      : x86_opcode_class
// Description : Combinational opcode/modrm classifier. With i_modrm_valid low
//               only the opcode is judged; modrm-dependent rules are skipped.
// Revision    : 1.0 - initial release
// ============================================================================
module x86_opcode_class
    import x86_dec_pkg::*;
(
    input  logic [7:0] i_opcode,
    input  logic [7:0] i_modrm,
    input  logic       i_modrm_valid,
    output logic       o_has_modrm,
    output logic [1:0] o_disp_size,
    output logic [1:0] o_imm_size,
    output logic       o_illegal
);

    logic [1:0] w_mod;
    logic [2:0] w_reg;
    logic [2:0] w_rm;
    logic       w_has_modrm;
    logic [1:0] w_disp_size;
    logic [1:0] w_imm_size;
    logic       w_illegal;

    assign w_mod = i_modrm[7:6];
    assign w_reg = i_modrm[5:3];
    assign w_rm  = i_modrm[2:0];

    always_comb begin
        w_has_modrm = 1'b0;
        w_disp_size = SZ_NONE;
        w_imm_size  = SZ_NONE;
        w_illegal   = 1'b0;
        case (i_opcode)
            OP_ADD_RM_R, OP_ADD_R_RM, OP_OR_RM_R, OP_MOV_RM_R, OP_MOV_R_RM: begin
                w_has_modrm = 1'b1;
            end
            OP_GRP1_IMM32: begin
                w_has_modrm = 1'b1;
                w_imm_size  = SZ_32;
                w_illegal   = i_modrm_valid && (w_reg > 3'd1);
            end
            OP_GRP1_IMM8: begin
                w_has_modrm = 1'b1;
                w_imm_size  = SZ_8;
                w_illegal   = i_modrm_valid && (w_reg > 3'd1);
            end
            OP_GRP2_IMM8: begin
                w_has_modrm = 1'b1;
                w_imm_size  = SZ_8;
                w_illegal   = i_modrm_valid && (w_reg != 3'd5);
            end
            OP_ADD_EAX_IMM, OP_OR_EAX_IMM: w_imm_size  = SZ_32;
            OP_JMP_REL8:                   w_disp_size = SZ_8;
            OP_CALL_REL32, OP_JMP_REL32:   w_disp_size = SZ_32;
            OP_RET:                        w_illegal   = 1'b0;
            default:                       w_illegal   = 1'b1;
        endcase

        if (w_has_modrm && i_modrm_valid) begin
            case (w_mod)
                2'b00:   w_disp_size = (w_rm == 3'b101) ? SZ_32 : SZ_NONE;
                2'b01:   w_disp_size = SZ_8;
                2'b10:   w_disp_size = SZ_32;
                default: w_disp_size = SZ_NONE;
            endcase
            // SIB addressing is not supported by the downstream datapath
            if ((w_mod != 2'b11) && (w_rm == 3'b100)) begin
                w_illegal = 1'b1;
            end
        end
    end

    assign o_has_modrm = w_has_modrm;
    assign o_illegal   = w_illegal;
    assign o_disp_size = w_illegal ? SZ_NONE : w_disp_size;
    assign o_imm_size  = w_illegal ? SZ_NONE : w_imm_size;

endmodule
`default_nettype wire

// File: rtl/x86_byte_decoder.sv
`default_nettype none
// ============================================================================
// Module      : x86_byte_decoder
// Description : Byte-serial x86 parser; assembles opcode/modrm/disp/imm into a
//               registered decoded-instruction record with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module x86_byte_decoder
    import x86_dec_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic [7:0]       i_byte_in,
    input  logic             i_byte_valid,
    output logic             o_byte_ready,
    output logic             o_instr_valid,
    input  logic             i_instr_ready,
    output logic [7:0]       o_opcode,
    output logic [7:0]       o_modrm,
    output logic [31:0]      o_disp32,
    output logic [31:0]      o_imm32,
    output logic             o_has_modrm,
    output logic [1:0]       o_disp_size,
    output logic [1:0]       o_imm_size,
    output logic [LEN_W-1:0] o_instr_len,
    output logic             o_illegal
);

    state_t           r_state;
    logic             r_byte_ready;
    logic             r_instr_valid;
    logic [7:0]       r_opcode;
    logic [7:0]       r_modrm;
    logic [31:0]      r_disp;
    logic [31:0]      r_imm;
    logic             r_has_modrm;
    logic [1:0]       r_disp_size;
    logic [1:0]       r_imm_size;
    logic [LEN_W-1:0] r_len;
    logic             r_illegal;
    logic [1:0]       r_cnt;

    logic       w_accept;
    logic       w_op_has_modrm, w_op_illegal;
    logic [1:0] w_op_disp_size, w_op_imm_size;
    logic       w_mr_has_modrm, w_mr_illegal;
    logic [1:0] w_mr_disp_size, w_mr_imm_size;
    state_t     w_opc_next, w_modrm_next, w_disp_next;
    logic       w_disp_last, w_imm_last;

    assign w_accept = i_byte_valid && r_byte_ready;

    x86_opcode_class u_class_opc (
        .i_opcode      (i_byte_in),
        .i_modrm       (8'h00),
        .i_modrm_valid (1'b0),
        .o_has_modrm   (w_op_has_modrm),
        .o_disp_size   (w_op_disp_size),
        .o_imm_size    (w_op_imm_size),
        .o_illegal     (w_op_illegal)
    );

    x86_opcode_class u_class_modrm (
        .i_opcode      (r_opcode),
        .i_modrm       (i_byte_in),
        .i_modrm_valid (1'b1),
        .o_has_modrm   (w_mr_has_modrm),
        .o_disp_size   (w_mr_disp_size),
        .o_imm_size    (w_mr_imm_size),
        .o_illegal     (w_mr_illegal)
    );

    assign w_opc_next   = next_field(w_op_illegal, w_op_has_modrm, w_op_disp_size, w_op_imm_size);
    assign w_modrm_next = next_field(w_mr_illegal, 1'b0, w_mr_disp_size, w_mr_imm_size);
    assign w_disp_next  = (r_imm_size != SZ_NONE) ? ST_IMM : ST_DONE;
    assign w_disp_last  = (r_disp_size == SZ_8) || (r_cnt == 2'd3);
    assign w_imm_last   = (r_imm_size == SZ_8) || (r_cnt == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_OPC;
            r_byte_ready  <= 1'b1;
            r_instr_valid <= 1'b0;
            r_opcode      <= 8'h00;
            r_modrm       <= 8'h00;
            r_disp        <= 32'h0;
            r_imm         <= 32'h0;
            r_has_modrm   <= 1'b0;
            r_disp_size   <= SZ_NONE;
            r_imm_size    <= SZ_NONE;
            r_len         <= '0;
            r_illegal     <= 1'b0;
            r_cnt         <= 2'd0;
        end else if (i_flush || ((r_state == ST_DONE) && i_instr_ready)) begin
            // Entry to OPC: abort or retire, leaving every field cleared
            r_state       <= ST_OPC;
            r_byte_ready  <= 1'b1;
            r_instr_valid <= 1'b0;
            r_opcode      <= 8'h00;
            r_modrm       <= 8'h00;
            r_disp        <= 32'h0;
            r_imm         <= 32'h0;
            r_has_modrm   <= 1'b0;
            r_disp_size   <= SZ_NONE;
            r_imm_size    <= SZ_NONE;
            r_len         <= '0;
            r_illegal     <= 1'b0;
            r_cnt         <= 2'd0;
        end else if (w_accept) begin
            r_len <= r_len + LEN_W'(1);
            case (r_state)
                ST_OPC: begin
                    r_opcode      <= i_byte_in;
                    r_has_modrm   <= w_op_has_modrm;
                    r_disp_size   <= w_op_disp_size;
                    r_imm_size    <= w_op_imm_size;
                    r_illegal     <= w_op_illegal;
                    r_cnt         <= 2'd0;
                    r_state       <= w_opc_next;
                    r_instr_valid <= (w_opc_next == ST_DONE);
                    r_byte_ready  <= (w_opc_next != ST_DONE);
                end
                ST_MODRM: begin
                    r_modrm       <= i_byte_in;
                    r_disp_size   <= w_mr_disp_size;
                    r_imm_size    <= w_mr_imm_size;
                    r_illegal     <= w_mr_illegal;
                    r_state       <= w_modrm_next;
                    r_instr_valid <= (w_modrm_next == ST_DONE);
                    r_byte_ready  <= (w_modrm_next != ST_DONE);
                end
                ST_DISP: begin
                    // Right shift lands an 8-bit field in [31:24] and a 32-bit field little-endian
                    r_disp <= {i_byte_in, r_disp[31:8]};
                    if (w_disp_last) begin
                        r_cnt         <= 2'd0;
                        r_state       <= w_disp_next;
                        r_instr_valid <= (w_disp_next == ST_DONE);
                        r_byte_ready  <= (w_disp_next != ST_DONE);
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                ST_IMM: begin
                    r_imm <= {i_byte_in, r_imm[31:8]};
                    if (w_imm_last) begin
                        r_cnt         <= 2'd0;
                        r_state       <= ST_DONE;
                        r_instr_valid <= 1'b1;
                        r_byte_ready  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: begin
                    r_state      <= ST_OPC;
                    r_byte_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_byte_ready  = r_byte_ready;
    assign o_instr_valid = r_instr_valid;
    assign o_opcode      = r_opcode;
    assign o_modrm       = r_modrm;
    assign o_disp32      = r_disp;
    assign o_imm32       = r_imm;
    assign o_has_modrm   = r_has_modrm;
    assign o_disp_size   = r_disp_size;
    assign o_imm_size    = r_imm_size;
    assign o_instr_len   = r_len;
    assign o_illegal     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_x86_byte_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_x86_byte_decoder
// Description : Directed-vector self-checking bench for x86_byte_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_x86_byte_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_flush;
    logic [7:0]  i_byte_in;
    logic        i_byte_valid;
    logic        o_byte_ready;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [7:0]  o_opcode;
    logic [7:0]  o_modrm;
    logic [31:0] o_disp32;
    logic [31:0] o_imm32;
    logic        o_has_modrm;
    logic [1:0]  o_disp_size;
    logic [1:0]  o_imm_size;
    logic [3:0]  o_instr_len;
    logic        o_illegal;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    x86_byte_decoder #(.LEN_W(4)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (i_flush),
        .i_byte_in     (i_byte_in),
        .i_byte_valid  (i_byte_valid),
        .o_byte_ready  (o_byte_ready),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .o_opcode      (o_opcode),
        .o_modrm       (o_modrm),
        .o_disp32      (o_disp32),
        .o_imm32       (o_imm32),
        .o_has_modrm   (o_has_modrm),
        .o_disp_size   (o_disp_size),
        .o_imm_size    (o_imm_size),
        .o_instr_len   (o_instr_len),
        .o_illegal     (o_illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one byte and hold it until the parser takes it (bounded wait)
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        i_byte_in    = b;
        i_byte_valid = 1'b1;
        while (!o_byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("send_ready", 32'(o_byte_ready), 32'd1);
        @(posedge clk);
        #1;
        i_byte_valid = 1'b0;
    endtask

    task automatic take(input string tag);
        i_instr_ready = 1'b1;
        @(posedge clk);
        #1;
        i_instr_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(o_instr_valid), 32'd0);
        check({tag, "_ready_rise"}, 32'(o_byte_ready), 32'd1);
    endtask

    task automatic check_rec(input string tag, input logic [7:0] op, input logic [7:0] mr,
                             input logic [31:0] d, input logic [31:0] im, input logic hm,
                             input logic [1:0] ds, input logic [1:0] is, input logic [3:0] len,
                             input logic ill);
        check({tag, "_valid"},  32'(o_instr_valid), 32'd1);
        check({tag, "_bready"}, 32'(o_byte_ready),  32'd0);
        check({tag, "_opcode"}, 32'(o_opcode),      32'(op));
        check({tag, "_modrm"},  32'(o_modrm),       32'(mr));
        check({tag, "_disp"},   o_disp32,           d);
        check({tag, "_imm"},    o_imm32,            im);
        check({tag, "_hasm"},   32'(o_has_modrm),   32'(hm));
        check({tag, "_dsz"},    32'(o_disp_size),   32'(ds));
        check({tag, "_isz"},    32'(o_imm_size),    32'(is));
        check({tag, "_len"},    32'(o_instr_len),   32'(len));
        check({tag, "_ill"},    32'(o_illegal),     32'(ill));
    endtask

    initial begin
        rst           = 1'b1;
        i_flush       = 1'b0;
        i_byte_in     = 8'h00;
        i_byte_valid  = 1'b0;
        i_instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid",  32'(o_instr_valid), 32'd0);
        check("rst_bready", 32'(o_byte_ready),  32'd1);
        check("rst_opcode", 32'(o_opcode),      32'd0);
        check("rst_disp",   o_disp32,           32'd0);
        check("rst_imm",    o_imm32,            32'd0);
        check("rst_len",    32'(o_instr_len),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // add eax-form group1 with imm8
        send(8'h83);
        send(8'hC0);
        check("t1_not_yet", 32'(o_instr_valid), 32'd0);
        send(8'h05);
        check_rec("t1", 8'h83, 8'hC0, 32'h0, 32'h0500_0000, 1'b1, 2'b00, 2'b01, 4'd3, 1'b0);
        take("t1");

        send(8'h81); send(8'h45); send(8'hF8);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        check_rec("t2", 8'h81, 8'h45, 32'hF800_0000, 32'h1234_5678, 1'b1, 2'b01, 2'b10, 4'd7, 1'b0);
        take("t2");

        send(8'h03); send(8'h05); send(8'h44); send(8'h33); send(8'h22); send(8'h11);
        check_rec("t3", 8'h03, 8'h05, 32'h1122_3344, 32'h0, 1'b1, 2'b10, 2'b00, 4'd6, 1'b0);
        take("t3");

        // held record: a byte is offered but must not be taken
        send(8'hEB); send(8'hFE);
        i_byte_in    = 8'hC3;
        i_byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_rec("t4_hold", 8'hEB, 8'h00, 32'hFE00_0000, 32'h0, 1'b0, 2'b01, 2'b00, 4'd2, 1'b0);
        end
        i_byte_valid = 1'b0;
        take("t4");

        send(8'h0F);
        check_rec("t5a", 8'h0F, 8'h00, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 4'd1, 1'b1);
        take("t5a");
        send(8'h01); send(8'h04);
        check_rec("t5b", 8'h01, 8'h04, 32'h0, 32'h0, 1'b1, 2'b00, 2'b00, 4'd2, 1'b1);
        take("t5b");
        send(8'hC3);
        check_rec("t5c", 8'hC3, 8'h00, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 4'd1, 1'b0);
        take("t5c");

        send(8'hC1); send(8'hE8); send(8'h03);
        check_rec("t6", 8'hC1, 8'hE8, 32'h0, 32'h0300_0000, 1'b1, 2'b00, 2'b01, 4'd3, 1'b0);
        take("t6");
        send(8'h83); send(8'hD0);
        check_rec("t7", 8'h83, 8'hD0, 32'h0, 32'h0, 1'b1, 2'b00, 2'b00, 4'd2, 1'b1);
        take("t7");

        // flush mid-instruction, with a byte offered in the flush cycle
        send(8'hE9); send(8'h11);
        i_flush      = 1'b1;
        i_byte_in    = 8'h22;
        i_byte_valid = 1'b1;
        @(posedge clk);
        #1;
        i_flush      = 1'b0;
        i_byte_valid = 1'b0;
        check("t8_flush_valid", 32'(o_instr_valid), 32'd0);
        check("t8_flush_len",   32'(o_instr_len),   32'd0);
        check("t8_flush_op",    32'(o_opcode),      32'd0);
        check("t8_flush_bready", 32'(o_byte_ready), 32'd1);
        send(8'hC3);
        check_rec("t8", 8'hC3, 8'h00, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 4'd1, 1'b0);
        take("t8");
        repeat (3) @(posedge clk);
        #1;
        check("t8_one_record", 32'(o_instr_valid), 32'd0);

        // asynchronous reset mid-instruction
        send(8'hE9); send(8'h11);
        #2 rst = 1'b1;
        #1;
        check("t9_rst_len", 32'(o_instr_len), 32'd0);
        check("t9_rst_op",  32'(o_opcode),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(8'hC3);
        check_rec("t9", 8'hC3, 8'h00, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 4'd1, 1'b0);
        take("t9");
        repeat (3) @(posedge clk);
        #1;
        check("t9_one_record", 32'(o_instr_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
